// File: rtl/pipe_scheduler.sv
// Purpose : scrolls N_PIPE pipe slots in Q8.4, recycles them with LFSR gaps, keeps score and collision.
// Latency : load takes N_PIPE cycles; tick to frame_done is N_PIPE+1 cycles.
// Backpr. : none; a tick while busy or in DONE is dropped and flagged on sticky overrun.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - pulse: reload every slot, clear score/collide/overrun (any state)
//   tick            - pulse: advance one frame (only accepted in RUN)
//   n_row, bird_alt - terminal rows and bird altitude, sampled as each slot is processed
//   pipes           - {position, max_bnd, min_bnd} per slot, slot i at [24*i +: 24]
//   score, collide  - pipes passed / sticky bird-pipe hit since start
//   busy            - high in LOAD and UPDATE
//   frame_done      - one-cycle pulse after the last slot of a frame is updated
//   overrun         - sticky: a tick arrived while the scheduler could not take it
module pipe_scheduler #(
   parameter int          N_PIPE  = 3,
   parameter int          SPACING = 50,
   parameter int          GAP     = 10,
   parameter int          STEP_Q4 = 5,
   parameter int          HIT_COL = 6,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  tick,
   input  logic [7:0]            n_row,
   input  logic [7:0]            bird_alt,
   output logic [24*N_PIPE-1:0]  pipes,
   output logic [15:0]           score,
   output logic                  collide,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   localparam int              IW   = (N_PIPE > 1) ? $clog2(N_PIPE) : 1;
   localparam logic [11:0]     STEP = 12'(STEP_Q4);
   localparam logic [11:0]     WRAP = 12'(N_PIPE * SPACING * 16);
   localparam logic [7:0]      GAP8 = 8'(GAP);
   localparam logic [7:0]      HIT8 = 8'(HIT_COL);
   localparam logic [IW-1:0]   LAST = IW'(N_PIPE - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_UPDATE, S_DONE} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [11:0]   pos_q [N_PIPE];
   logic [7:0]    min_q [N_PIPE];
   logic [7:0]    max_q [N_PIPE];
   logic [15:0]   lfsr_q;

   logic [15:0]   lfsr_nxt;
   logic [7:0]    gap_raw, gap_lim, gap_top, gen_min, gen_max;
   logic [11:0]   cur_pos, dec_pos, load_pos;
   logic [7:0]    cur_min, cur_max;
   logic          recycle, hit;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
   assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   // Gap from the low nibble; pulled down so max_bnd stays within n_row-2.
   // Deliberately 8-bit throughout, so tiny n_row values wrap.
   always_comb begin
      gap_raw = 8'd2 + {4'd0, lfsr_q[3:0]};
      gap_lim = n_row - 8'd2;
      gap_top = gap_raw + GAP8;
      gen_min = (gap_top > gap_lim) ? (gap_lim - GAP8) : gap_raw;
      gen_max = gen_min + GAP8;
   end

   // Select the slot currently addressed by idx.
   always_comb begin
      cur_pos  = '0;
      cur_min  = '0;
      cur_max  = '0;
      load_pos = '0;
      for (int i = 0; i < N_PIPE; i++) begin
         if (idx == IW'(i)) begin
            cur_pos  = pos_q[i];
            cur_min  = min_q[i];
            cur_max  = max_q[i];
            load_pos = 12'((i + 1) * SPACING * 16);
         end
      end
   end

   assign recycle = (cur_pos < STEP);
   assign dec_pos = cur_pos - STEP;
   // Only meaningful for a non-recycled slot; uses that slot's existing gap.
   assign hit     = (dec_pos[11:4] <= HIT8) && ((bird_alt >= cur_max) || (bird_alt <= cur_min));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         lfsr_q     <= SEED;
         score      <= '0;
         collide    <= 1'b0;
         overrun    <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < N_PIPE; i++) begin
            pos_q[i] <= '0;
            min_q[i] <= '0;
            max_q[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         if (start) begin
            // Start preempts everything; a coincident tick is simply dropped.
            state <= S_LOAD;
            idx   <= '0;
         end else begin
            case (state)
               S_IDLE: ;
               S_LOAD: begin
                  for (int i = 0; i < N_PIPE; i++) begin
                     if (idx == IW'(i)) begin
                        pos_q[i] <= load_pos;
                        min_q[i] <= gen_min;
                        max_q[i] <= gen_max;
                     end
                  end
                  lfsr_q <= lfsr_nxt;
                  if (idx == '0) begin
                     score   <= '0;
                     collide <= 1'b0;
                     overrun <= 1'b0;
                  end
                  if (idx == LAST) begin
                     state <= S_RUN;
                     idx   <= '0;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
               S_RUN: begin
                  if (tick) begin
                     state <= S_UPDATE;
                     idx   <= '0;
                  end
               end
               S_UPDATE: begin
                  for (int i = 0; i < N_PIPE; i++) begin
                     if (idx == IW'(i)) begin
                        if (recycle) begin
                           pos_q[i] <= dec_pos + WRAP;
                           min_q[i] <= gen_min;
                           max_q[i] <= gen_max;
                        end else begin
                           pos_q[i] <= dec_pos;
                        end
                     end
                  end
                  if (recycle) begin
                     lfsr_q <= lfsr_nxt;
                     if (score != 16'hFFFF)
                        score <= score + 16'd1;
                  end else if (hit) begin
                     collide <= 1'b1;
                  end
                  if (idx == LAST) begin
                     state      <= S_DONE;
                     idx        <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
               S_DONE: state <= S_RUN;
               default: state <= S_IDLE;
            endcase
            // After the case so a tick on the first LOAD cycle still flags.
            if (tick && ((state == S_LOAD) || (state == S_UPDATE) || (state == S_DONE)))
               overrun <= 1'b1;
         end
      end
   end

   assign busy = (state == S_LOAD) || (state == S_UPDATE);

   for (genvar g = 0; g < N_PIPE; g++) begin : g_pack
      assign pipes[24*g +: 24] = {pos_q[g][11:4], max_q[g], min_q[g]};
   end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
Sequences the scrolling pipe obstacles for the playing scene, replacing the per-frame real-valued position update in the controller. It owns N_PIPE pipe slots in fixed point, advances them one slot per cycle on each frame tick, recycles slots that scroll past the left edge with fresh LFSR-generated gaps, and reports score and bird/pipe collision. Output `pipes` uses the existing packed format consumed by the view: {position, max_bnd, min_bnd} per slot, slot i at bits [24*i +: 24].

Parameters:
N_PIPE, 3, number of pipe slots
SPACING, 50, initial and recycle column spacing between slots (integer columns)
GAP, 10, max_bnd - min_bnd for every generated gap
STEP_Q4, 5, per-tick leftward move in Q8.4 (5 = 0.3125 columns)
HIT_COL, 6, bird/pipe horizontal overlap when integer position <= HIT_COL
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: (re)load all slots and clear score, accepted in any state
tick  in  1  pulse: advance one frame (controller drives it only while scene == PLAYING)
n_row  in  8  terminal rows
bird_alt  in  8  bird altitude (integer, same units as the gap bounds)
pipes  out  24*N_PIPE  packed {position[7:0], max_bnd[7:0], min_bnd[7:0]} per slot
score  out  16  pipes passed since start
collide  out  1  sticky: bird hit a pipe since start
busy  out  1  high in LOAD and UPDATE
frame_done  out  1  single-cycle pulse after the last slot of a frame is updated
overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset (async): state IDLE; pipes = 0; internal Q8.4 positions = 0; score = 0; collide = 0; overrun = 0; frame_done = 0; LFSR = SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts exactly once per slot loaded or recycled, and never otherwise.
- Gap generation from the current LFSR value L: min_bnd = 2 + L[3:0]; if min_bnd + GAP > n_row - 2, then min_bnd = n_row - 2 - GAP. max_bnd = min_bnd + GAP. All arithmetic is 8-bit unsigned.
- States:
  - IDLE: waits for start. Ticks are ignored and do not set overrun.
  - LOAD: one slot per cycle, i = 0..N_PIPE-1. pos_q[i] = SPACING*(i+1) << 4; gap is generated. Score, collide and overrun clear on the first LOAD cycle. After slot N_PIPE-1 the state goes to RUN. Load takes N_PIPE cycles.
  - RUN: on tick, go to UPDATE with i = 0.
  - UPDATE: one slot per cycle.
    - If pos_q[i] >= STEP_Q4: pos_q[i] -= STEP_Q4.
    - Otherwise the slot recycles: pos_q[i] = pos_q[i] - STEP_Q4 + (N_PIPE*SPACING << 4), taken mod 2^12. A new gap is generated, and score increments, saturating at 16'hFFFF.
    - Collision check runs on the updated slot, non-recycled only: if (pos_q[i] >> 4) <= HIT_COL and (bird_alt >= max_bnd or bird_alt <= min_bnd), set collide.
    - After slot N_PIPE-1 the state goes to DONE.
  - DONE: frame_done = 1 for this one cycle, then RUN.
  - Tick-to-frame_done latency is N_PIPE+1 cycles.
- The pipes output field for slot i updates in the same cycle its pos_q or gap updates. position = pos_q[11:4]. Other slots hold their values.
- Ticks in LOAD, UPDATE or DONE are dropped and set overrun. A tick in the same cycle as start is dropped and does not set overrun.
- start in any state wins: the next state is LOAD from slot 0, and any in-progress update is abandoned. The LFSR is not reseeded.
- bird_alt and n_row are sampled on the cycle each slot is processed.
- busy = (state == LOAD || state == UPDATE).

Test Plan:
- Reset, then start with n_row=40 -> after 3 cycles busy=0. Positions are 50/100/150. LFSR=ACE1 gives L[3:0]=1, so slot0 min=3, max=13. Score=0.
- Start, then 160 ticks spaced 8 cycles apart -> slot0 position = (800-800)>>4 = 0, with no recycle yet. The 161st tick recycles slot0: pos_q = 0-5+2400 = 2395, so position 149. Score=1 and frame_done pulses every tick.
- bird_alt=20 with a slot at position 5, min=3, max=13 -> collide=1 and stays 1 until the next start.
- bird_alt=8 with the same slot -> collide stays 0.
- n_row=12 with L[3:0]=15 -> min clamps to 12-2-10 = 0 and max = 10.
- Tick issued 1 cycle after a prior tick -> overrun=1, and only one frame is applied (single position decrement of 5).
- Start asserted mid-UPDATE (slot 1) -> all slots reload. Slot 2 is not advanced, and the first LOAD cycle occurs the cycle after start.
